// File: rtl/mem_arbiter.sv
// Purpose: arbitrates a single-port unified memory between instruction fetch (port 0) and data (port 1).
// Latency: gnt/mem_en are combinational in the request cycle; read data returns MEM_LATENCY cycles later.
// Backpressure: one transaction outstanding; requesters see gnt=0 and hold req until IDLE re-arbitrates.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   if_req/if_addr                  port 0 read request (read-only)
//   if_gnt/if_rvalid/if_rdata       port 0 accept strobe and read return
//   d_req/d_we/d_addr/d_wdata       port 1 read/write request
//   d_gnt/d_rvalid/d_rdata          port 1 accept strobe and read return
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory side
`ifndef WORD
`define WORD [31:0]
`endif

module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic `WORD if_addr,
    output logic       if_gnt,
    output logic       if_rvalid,
    output logic `WORD if_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic `WORD d_addr,
    input  logic `WORD d_wdata,
    output logic       d_gnt,
    output logic       d_rvalid,
    output logic `WORD d_rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic `WORD mem_addr,
    output logic `WORD mem_wdata,
    input  logic `WORD mem_rdata
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner;      // port that owns the outstanding read
    logic          last;       // port granted most recently (round-robin pointer)

    logic idle;
    logic gnt0;
    logic gnt1;
    logic rd_grant;
    logic resp;

    assign idle = (state == IDLE) && !rst;

    // Port 0 wins a tie when port 1 was granted last, and vice versa.
    assign gnt0 = idle && if_req && (!d_req || last);
    assign gnt1 = idle && d_req && (!if_req || !last);

    // Writes retire in the grant cycle; only reads occupy the memory afterwards.
    assign rd_grant = gnt0 || (gnt1 && !d_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        last <= gnt1;
                    end
                    if (rd_grant) begin
                        owner <= gnt1;
                        cnt   <= CW'(MEM_LATENCY - 1);
                        state <= (MEM_LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    // Counter holds the remaining WAIT cycles; leaving on 1 lands
                    // RESP exactly MEM_LATENCY cycles after the grant.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (cnt <= CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt = gnt0;
    assign d_gnt  = gnt1;

    assign mem_en    = gnt0 || gnt1;
    assign mem_we    = gnt1 && d_we;
    assign mem_addr  = gnt1 ? d_addr : (gnt0 ? if_addr : '0);
    assign mem_wdata = gnt1 ? d_wdata : '0;

    assign resp      = (state == RESP) && !rst;
    assign if_rvalid = resp && !owner;
    assign d_rvalid  = resp && owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter at MEM_LATENCY=2 (u_a) and MEM_LATENCY=1 (u_b).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: requesters are modelled as holding req per the scenario tables.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(2)) u_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(1)) u_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
    endtask

    // Leaves the bench at the start of cycle 1 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [133:0] obs;
        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_0080;
        d_wdata   = 32'hCAFE_F00D;
        mem_rdata = 32'h1234_5678;
        tick();
        @(negedge clk);
        obs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, want all zero", obs);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        do_reset();
        // cycle 1
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        d_wdata   = 32'hFFFF_FFFF;
        mem_rdata = 32'h0050_0093;
        @(negedge clk);
        vectors++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid} !== 5'b10100) begin
            miscompares++;
            $display("FAIL fetch_c1_ctrl: got %b, want 10100", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid});
        end
        vectors++;
        if ({mem_addr, mem_wdata, if_rdata} !== {32'h10, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL fetch_c1_bus: addr %h wdata %h rdata %h, want 10 0 0", mem_addr, mem_wdata, if_rdata);
        end
        tick();
        // cycle 2
        if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if_gnt, mem_en, if_rvalid} !== 3'b000 || if_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL fetch_c2: gnt/en/rvalid %b rdata %h, want 000 0", {if_gnt, mem_en, if_rvalid}, if_rdata);
        end
        tick();
        // cycle 3
        @(negedge clk);
        vectors++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL fetch_c3: rvalid %b rdata %h, want 10 00500093", {if_rvalid, d_rvalid}, if_rdata);
        end
        tick();
        // cycle 4: response is a single cycle
        @(negedge clk);
        vectors++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL fetch_c4: rvalid %b rdata %h, want 0 0", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_contention();
        logic [7:1] e_ig = 7'b1000001;
        logic [7:1] e_dg = 7'b0001000;
        logic [7:1] e_ir = 7'b0000100;
        logic [7:1] e_dr = 7'b0100000;
        logic [31:0] e_addr;
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0020;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0040;
        mem_rdata = 32'h1111_2222;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e_addr = e_dg[c] ? 32'h40 : (e_ig[c] ? 32'h20 : 32'h0);
            vectors++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en} !== {e_ig[c], e_dg[c], e_ir[c], e_dr[c], e_ig[c] | e_dg[c]}) begin
                miscompares++;
                $display("FAIL contention_c%0d: gnt0 gnt1 rv0 rv1 en = %b, want %b", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en},
                         {e_ig[c], e_dg[c], e_ir[c], e_dr[c], e_ig[c] | e_dg[c]});
            end
            vectors++;
            if (mem_addr !== e_addr || if_rdata !== (e_ir[c] ? 32'h1111_2222 : 32'h0) ||
                d_rdata !== (e_dr[c] ? 32'h1111_2222 : 32'h0)) begin
                miscompares++;
                $display("FAIL contention_bus_c%0d: addr %h rdata0 %h rdata1 %h, want addr %h", c,
                         mem_addr, if_rdata, d_rdata, e_addr);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0080;
        d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (c < 3) begin
                if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b1110 || mem_addr !== d_addr ||
                    mem_wdata !== 32'hDEAD_BEEF) begin
                    miscompares++;
                    $display("FAIL write_c%0d: gnt/en/we/rv %b addr %h wdata %h, want 1110 %h deadbeef", c,
                             {d_gnt, mem_en, mem_we, d_rvalid}, mem_addr, mem_wdata, d_addr);
                end
            end else begin
                if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL write_c3: gnt/en/we/rv %b, want 0000", {d_gnt, mem_en, mem_we, d_rvalid});
                end
            end
            tick();
            d_addr = 32'h0000_0084;
            if (c == 2) d_req = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (d_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL write_no_rvalid: got %b, want 0", d_rvalid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0030;
        mem_rdata = 32'hABCD_0123;
        @(negedge clk);
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_grant: got %b, want 1", if_gnt);
        end
        tick();
        // cycles 2 and 3 in reset with both ports requesting
        rst    = 1'b1;
        d_req  = 1'b1;
        d_addr = 32'h0000_0040;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0 ||
                {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
                miscompares++;
                $display("FAIL midreset_c%0d: ctrl %b bus %h, want all zero", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we},
                         {mem_addr, mem_wdata, if_rdata, d_rdata});
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if_gnt, d_gnt, if_rvalid} !== 3'b100 || mem_addr !== 32'h30) begin
            miscompares++;
            $display("FAIL midreset_after: gnt0 gnt1 rv0 %b addr %h, want 100 30",
                     {if_gnt, d_gnt, if_rvalid}, mem_addr);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back_lat1();
        logic [6:1] e_ig = 6'b010101;
        logic [6:1] e_ir = 6'b101010;
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        mem_rdata = 32'h5A5A_A5A5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if ({if_gnt_b, if_rvalid_b, mem_en_b} !== {e_ig[c], e_ir[c], e_ig[c]} ||
                if_rdata_b !== (e_ir[c] ? 32'h5A5A_A5A5 : 32'h0)) begin
                miscompares++;
                $display("FAIL lat1_c%0d: gnt rv en %b rdata %h, want %b", c,
                         {if_gnt_b, if_rvalid_b, mem_en_b}, if_rdata_b, {e_ig[c], e_ir[c], e_ig[c]});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_withdrawn_req();
        do_reset();
        if_req = 1'b1;
        if_addr = 32'h0000_0010;
        @(negedge clk);
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL withdraw_c1: if_gnt %b, want 1", if_gnt);
        end
        tick();
        // cycle 2: data request pulses while fetch is in WAIT
        if_req = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h0000_0040;
        @(negedge clk);
        vectors++;
        if ({d_gnt, if_gnt, mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL withdraw_c2: d_gnt if_gnt en %b, want 000", {d_gnt, if_gnt, mem_en});
        end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (if_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL withdraw_c3: if_rvalid %b, want 1", if_rvalid);
        end
        tick();
        // cycle 4: contention must still favour port 1
        if_req = 1'b1;
        d_req  = 1'b1;
        @(negedge clk);
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b01 || mem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL withdraw_c4: gnt0 gnt1 %b addr %h, want 01 40", {if_gnt, d_gnt}, mem_addr);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_write();
        test_reset_mid_read();
        test_back_to_back_lat1();
        test_withdrawn_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
